text_console_ctrl: RTL and testbench
====================================

Name:
text_console_ctrl

Overview:
- Hardware terminal engine for the text layer. Accepts a ready/valid byte stream from the CPU side and writes the result into the 32x32-entry text table (TXBL).
- Tracks a cursor and handles control characters.
- Performs screen scroll (copy rows up, blank the last row) and full-screen clear autonomously.
- Shares the TXBL write port with direct CPU VRAM writes; CPU writes always win.

Parameters:
- ROWS, 30: visible rows handled by the engine (rows ROWS..31 never touched).
- COLS, 32: columns per row.
- FILL_CHAR, 8'h20: byte written to blanked cells (colour bit 0).

Ports:
- cpu_clk  input  1: sole clock; all logic on posedge.
- rst  input  1: synchronous, active-high reset.
- char_valid  input  1: byte offered.
- char_data  input  8: byte; bit 7 ignored for printables.
- char_color  input  1: colour-select bit stored in TXBL[7] with the character.
- char_ready  output  1: engine can accept a byte.
- busy  output  1: engine not IDLE.
- cursor_row  output  5: current cursor row.
- cursor_col  output  5: current cursor column.
- cpu_we  input  1: direct CPU TXBL write request.
- cpu_addr  input  10: direct write address {row,col}.
- cpu_data  input  8: direct write data.
- txbl_we  output  1: TXBL write strobe.
- txbl_waddr  output  10: TXBL write address {row[4:0],col[4:0]}.
- txbl_wdata  output  8: TXBL write data.
- txbl_raddr  output  10: TXBL read address (registered by TXBL).
- txbl_rdata  input  8: read data, valid one cycle after txbl_raddr.

Behaviour:
- Reset:
  - state=IDLE, cursor=(0,0), char_ready=0 while rst is high, busy=0.
  - Engine write request deasserted; txbl_we follows cpu_we only.
  - txbl_raddr=0.
- Write mux (combinational):
  - cpu_we=1: txbl_we=1 with the cpu_addr/cpu_data pass-through; any engine write that cycle stalls (state and counters hold).
  - cpu_we=0: the engine request drives the port.
- Handshake: char_ready = (state==IDLE) & ~rst. A byte is taken on posedge when char_valid & char_ready. One byte per transaction; char_ready drops the cycle after accept.
- States:
  - IDLE: on accept, decode:
    - printable 0x20-0x7F (char_data[7] masked): latch {char_color,char_data[6:0]} -> PUT.
    - 0x0A LF: col=0, then ADVANCE_ROW.
    - 0x0D CR: col=0 -> IDLE.
    - 0x08 BS: col>0: col-=1, latch FILL_CHAR -> PUT_BS. col==0: no-op.
    - 0x0C FF: clear counter=0 -> CLEAR.
    - all other bytes: consumed, no effect.
  - PUT: write latched byte at (row,col); retries while stalled.
    - col<COLS-1: col+=1 -> IDLE.
    - col==COLS-1: col=0, then ADVANCE_ROW.
  - PUT_BS: write FILL_CHAR at (row,col); cursor unchanged -> IDLE.
  - ADVANCE_ROW (resolved same cycle):
    - row<ROWS-1: row+=1 -> IDLE.
    - row==ROWS-1: row unchanged, scroll counter (r=0,c=0) -> COPY_RD.
  - COPY_RD: txbl_raddr={r+1,c} -> COPY_WR.
  - COPY_WR: write txbl_rdata to {r,c}. A stall holds the state; txbl_raddr is held so rdata stays valid.
    - After write: c+=1. On c wrap, r+=1.
    - After (ROWS-2,COLS-1): c=0 -> BLANK.
    - Otherwise -> COPY_RD.
  - BLANK: write FILL_CHAR to {ROWS-1,c}, c+=1. After c==COLS-1 -> IDLE.
  - CLEAR: write FILL_CHAR to every {r,c}, r in 0..ROWS-1, one cell per unstalled cycle. After the last cell: cursor=(0,0) -> IDLE.
- Timing (no stalls):
  - Printable: write 1 cycle after accept, char_ready back 2 cycles after accept.
  - Scroll: 2*(ROWS-1)*COLS + COLS cycles = 1888.
  - Clear: ROWS*COLS = 960 cycles.
- Widths: row/col counters 5 bits; addresses are {row,col} concatenated without arithmetic. Rows 30/31 never read or written by the engine.
- Reset mid-operation: aborts immediately to the reset state; partially scrolled or cleared TXBL contents remain as-is.
- A CPU direct write to a cell currently being copied is not protected; the last writer wins.

Optional Feature:
- Macro TXCON_TAB_EN.
- Defined: 0x09 TAB sets col to the next multiple of 4 (col | 3) + 1. If the result reaches COLS: col=0 and ADVANCE_ROW (may scroll). No cells are written.
- Undefined: 0x09 is consumed with no effect, like other unhandled controls.

Test Plan:
- Reset, then send 'A' (0x41) with color=1 -> txbl_we at waddr 0x000, wdata 0xC1 one cycle after accept; cursor=(0,1); char_ready high 2 cycles after accept.
- Cursor at (5,31), send 'Z' -> write 0x5A at {5,31}; cursor=(6,0); no scroll.
- Fill row 29 and row 1 with known values, cursor (29,0), send LF -> busy for 1888 cycles; row 0 holds old row 1, row 28 holds old row 29, row 29 all 0x20, rows 30/31 unchanged; cursor=(29,0).
- During scroll, assert cpu_we every 3rd cycle to address 0x3E0 with data 0x55 -> those cycles carry the CPU write; scroll result otherwise correct; total duration extended by exactly the number of stalled engine write cycles; 0x3E0 ends 0x55.
- Send 0x0C from cursor (10,7) -> 960 writes of 0x20 covering 0x000-0x3BF; cursor=(0,0). Then BS at col 0 -> no write, cursor unchanged.
- TXCON_TAB_EN defined, cursor (3,5), send 0x09 -> cursor (3,8). From (3,30) -> (4,0). Macro undefined -> cursor unchanged.

Source files
------------

// File: rtl/text_console_ctrl.sv
// Text-layer terminal engine: turns a ready/valid byte stream into TXBL writes with
// cursor tracking, scroll and clear. Optional TAB handling under `TXCON_TAB_EN.
module text_console_ctrl #(
  parameter int         ROWS      = 30,
  parameter int         COLS      = 32,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic       cpu_clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  input  logic       char_color,
  output logic       char_ready,
  output logic       busy,
  output logic [4:0] cursor_row,
  output logic [4:0] cursor_col,
  input  logic       cpu_we,
  input  logic [9:0] cpu_addr,
  input  logic [7:0] cpu_data,
  output logic       txbl_we,
  output logic [9:0] txbl_waddr,
  output logic [7:0] txbl_wdata,
  output logic [9:0] txbl_raddr,
  input  logic [7:0] txbl_rdata
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PUT     = 3'd1;
  localparam logic [2:0] S_PUT_BS  = 3'd2;
  localparam logic [2:0] S_COPY_RD = 3'd3;
  localparam logic [2:0] S_COPY_WR = 3'd4;
  localparam logic [2:0] S_BLANK   = 3'd5;
  localparam logic [2:0] S_CLEAR   = 3'd6;

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [4:0] PEN_ROW  = 5'(ROWS - 2);
  localparam logic [4:0] LAST_COL = 5'(COLS - 1);

  logic [2:0] r_state;
  logic [4:0] r_row;
  logic [4:0] r_col;
  logic [4:0] r_cnt_r;
  logic [4:0] r_cnt_c;
  logic [7:0] r_char;
  logic [9:0] r_raddr;

  logic       w_eng_we;
  logic [9:0] w_eng_addr;
  logic [7:0] w_eng_data;
  logic       w_stall;
  logic       w_accept;
  logic [9:0] w_raddr;
  logic [2:0] w_adv_state;
  logic [4:0] w_adv_row;

  // Valid/ready: a byte transfers on the rising edge where char_valid and
  // char_ready are both high; char_ready is only offered in IDLE, outside reset.
  assign char_ready = (r_state == S_IDLE) & ~rst;
  assign w_accept   = char_valid & char_ready;
  assign busy       = (r_state != S_IDLE);
  assign cursor_row = r_row;
  assign cursor_col = r_col;

  always_comb begin
    w_eng_we   = 1'b0;
    w_eng_addr = {r_row, r_col};
    w_eng_data = FILL_CHAR;
    case (r_state)
      S_PUT: begin
        w_eng_we   = 1'b1;
        w_eng_data = r_char;
      end
      S_PUT_BS: w_eng_we = 1'b1;
      S_COPY_WR: begin
        w_eng_we   = 1'b1;
        w_eng_addr = {r_cnt_r, r_cnt_c};
        w_eng_data = txbl_rdata;
      end
      S_BLANK: begin
        w_eng_we   = 1'b1;
        w_eng_addr = {LAST_ROW, r_cnt_c};
      end
      S_CLEAR: begin
        w_eng_we   = 1'b1;
        w_eng_addr = {r_cnt_r, r_cnt_c};
      end
      default: ;
    endcase
    if (rst) w_eng_we = 1'b0;
  end

  // CPU direct writes own the port; a colliding engine write retries next cycle.
  assign w_stall    = cpu_we & w_eng_we;
  assign txbl_we    = cpu_we | w_eng_we;
  assign txbl_waddr = cpu_we ? cpu_addr : w_eng_addr;
  assign txbl_wdata = cpu_we ? cpu_data : w_eng_data;

  // Read address is held outside COPY_RD so a stalled COPY_WR keeps valid rdata.
  assign w_raddr    = (r_state == S_COPY_RD) ? {r_cnt_r + 5'd1, r_cnt_c} : r_raddr;
  assign txbl_raddr = w_raddr;

  assign w_adv_state = (r_row == LAST_ROW) ? S_COPY_RD : S_IDLE;
  assign w_adv_row   = (r_row == LAST_ROW) ? r_row : r_row + 5'd1;

`ifdef TXCON_TAB_EN
  logic [5:0] w_tab_col;
  logic       w_tab_wrap;
  assign w_tab_col  = ({1'b0, r_col} | 6'd3) + 6'd1;
  assign w_tab_wrap = (w_tab_col >= 6'(COLS));
`endif

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_row   <= 5'd0;
      r_col   <= 5'd0;
      r_cnt_r <= 5'd0;
      r_cnt_c <= 5'd0;
      r_char  <= FILL_CHAR;
      r_raddr <= 10'd0;
    end else begin
      r_raddr <= w_raddr;
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (char_data[6:0] >= 7'h20) begin
            r_char  <= {char_color, char_data[6:0]};
            r_state <= S_PUT;
          end else begin
            case (char_data)
              8'h0A: begin
                r_col   <= 5'd0;
                r_row   <= w_adv_row;
                r_state <= w_adv_state;
                r_cnt_r <= 5'd0;
                r_cnt_c <= 5'd0;
              end
              8'h0D: r_col <= 5'd0;
              8'h08: if (r_col != 5'd0) begin
                r_col   <= r_col - 5'd1;
                r_state <= S_PUT_BS;
              end
              8'h0C: begin
                r_cnt_r <= 5'd0;
                r_cnt_c <= 5'd0;
                r_state <= S_CLEAR;
              end
`ifdef TXCON_TAB_EN
              8'h09: if (w_tab_wrap) begin
                r_col   <= 5'd0;
                r_row   <= w_adv_row;
                r_state <= w_adv_state;
                r_cnt_r <= 5'd0;
                r_cnt_c <= 5'd0;
              end else begin
                r_col <= w_tab_col[4:0];
              end
`endif
              default: ;
            endcase
          end
        end
        S_PUT: if (!w_stall) begin
          if (r_col != LAST_COL) begin
            r_col   <= r_col + 5'd1;
            r_state <= S_IDLE;
          end else begin
            r_col   <= 5'd0;
            r_row   <= w_adv_row;
            r_state <= w_adv_state;
            r_cnt_r <= 5'd0;
            r_cnt_c <= 5'd0;
          end
        end
        S_PUT_BS: if (!w_stall) r_state <= S_IDLE;
        S_COPY_RD: r_state <= S_COPY_WR;
        S_COPY_WR: if (!w_stall) begin
          if (r_cnt_c == LAST_COL) begin
            r_cnt_c <= 5'd0;
            if (r_cnt_r == PEN_ROW) begin
              r_state <= S_BLANK;
            end else begin
              r_cnt_r <= r_cnt_r + 5'd1;
              r_state <= S_COPY_RD;
            end
          end else begin
            r_cnt_c <= r_cnt_c + 5'd1;
            r_state <= S_COPY_RD;
          end
        end
        S_BLANK: if (!w_stall) begin
          r_cnt_c <= r_cnt_c + 5'd1;
          if (r_cnt_c == LAST_COL) r_state <= S_IDLE;
        end
        S_CLEAR: if (!w_stall) begin
          if (r_cnt_c == LAST_COL) begin
            r_cnt_c <= 5'd0;
            if (r_cnt_r == LAST_ROW) begin
              r_row   <= 5'd0;
              r_col   <= 5'd0;
              r_state <= S_IDLE;
            end else begin
              r_cnt_r <= r_cnt_r + 5'd1;
            end
          end else begin
            r_cnt_c <= r_cnt_c + 5'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Bench for text_console_ctrl: TXBL memory model, screen-level reference model and
// directed plus randomized byte streams.
module tb_text_console_ctrl;

  localparam int ROWS = 30;
  localparam int COLS = 32;

  logic       cpu_clk;
  logic       rst;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_color;
  logic       char_ready;
  logic       busy;
  logic [4:0] cursor_row;
  logic [4:0] cursor_col;
  logic       cpu_we;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_data;
  logic       txbl_we;
  logic [9:0] txbl_waddr;
  logic [7:0] txbl_wdata;
  logic [9:0] txbl_raddr;
  logic [7:0] txbl_rdata;

  text_console_ctrl #(.ROWS(ROWS), .COLS(COLS), .FILL_CHAR(8'h20)) dut (
    .cpu_clk   (cpu_clk),
    .rst       (rst),
    .char_valid(char_valid),
    .char_data (char_data),
    .char_color(char_color),
    .char_ready(char_ready),
    .busy      (busy),
    .cursor_row(cursor_row),
    .cursor_col(cursor_col),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .txbl_we   (txbl_we),
    .txbl_waddr(txbl_waddr),
    .txbl_wdata(txbl_wdata),
    .txbl_raddr(txbl_raddr),
    .txbl_rdata(txbl_rdata)
  );

  // Clock / reset
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // TXBL memory with registered read
  logic [7:0] mem [0:1023];
  always @(posedge cpu_clk) begin
    if (txbl_we) mem[txbl_waddr] <= txbl_wdata;
    txbl_rdata <= mem[txbl_raddr];
  end

  // Port monitor: engine writes and carried CPU writes
  logic [17:0] eng_log[$];
  int          cpu55_cnt = 0;
  always @(posedge cpu_clk) begin
    if (txbl_we && !cpu_we) eng_log.push_back({txbl_waddr, txbl_wdata});
    if (txbl_we && cpu_we && txbl_waddr == 10'h3E0 && txbl_wdata == 8'h55) cpu55_cnt++;
  end

  // Scoreboard and screen model
  logic [17:0] exp_q[$];
  logic [7:0]  exp_mem [0:1023];
  int          m_row, m_col;
  int          total = 0;
  int          bad   = 0;
  int          log_base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int addr_of(input int r, input int c);
    return r * COLS + c;
  endfunction

  task automatic m_adv_row();
    if (m_row < ROWS - 1) m_row++;
    else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) exp_mem[addr_of(r, c)] = exp_mem[addr_of(r + 1, c)];
      for (int c = 0; c < COLS; c++) exp_mem[addr_of(ROWS - 1, c)] = 8'h20;
    end
  endtask

  task automatic m_char(input logic [7:0] d, input logic color);
    logic [7:0] b;
    int         n;
    if (d[6:0] >= 7'h20) begin
      b = {color, d[6:0]};
      exp_mem[addr_of(m_row, m_col)] = b;
      exp_q.push_back({10'(addr_of(m_row, m_col)), b});
      if (m_col < COLS - 1) m_col++;
      else begin m_col = 0; m_adv_row(); end
    end else if (d == 8'h0A) begin
      m_col = 0;
      m_adv_row();
    end else if (d == 8'h0D) begin
      m_col = 0;
    end else if (d == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        exp_mem[addr_of(m_row, m_col)] = 8'h20;
        exp_q.push_back({10'(addr_of(m_row, m_col)), 8'h20});
      end
    end else if (d == 8'h0C) begin
      for (int i = 0; i < ROWS * COLS; i++) exp_mem[i] = 8'h20;
      m_row = 0;
      m_col = 0;
    end else if (d == 8'h09) begin
`ifdef TXCON_TAB_EN
      n = (m_col | 3) + 1;
      if (n >= COLS) begin m_col = 0; m_adv_row(); end
      else m_col = n;
`else
      n = 0;
`endif
    end
  endtask

  // Expected busy duration of a scroll, optionally with CPU writes on every cycle k%3==2
  function automatic int sched(input bit stall);
    int k = 0;
    for (int i = 0; i < (ROWS - 1) * COLS; i++) begin
      k++;
      while (stall && (k % 3 == 2)) k++;
      k++;
    end
    for (int i = 0; i < COLS; i++) begin
      while (stall && (k % 3 == 2)) k++;
      k++;
    end
    return k;
  endfunction

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (char_ready !== 1'b1 && k < 5000) begin tick(); k++; end
    if (k >= 5000) chk("ready_timeout", 32'(char_ready), 32'd1);
  endtask

  task automatic wait_idle(output int dur);
    int k = 0;
    while (busy !== 1'b0 && k < 5000) begin tick(); k++; end
    if (k >= 5000) chk("idle_timeout", 32'(busy), 32'd0);
    dur = k;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic color);
    wait_ready();
    char_valid = 1'b1;
    char_data  = d;
    char_color = color;
    tick();
    char_valid = 1'b0;
    m_char(d, color);
  endtask

  task automatic send(input logic [7:0] d, input logic color);
    int dur;
    push_byte(d, color);
    wait_idle(dur);
  endtask

  task automatic run_bulk(input bit stall, output int dur);
    int k = 0;
    while (busy === 1'b1 && k < 6000) begin
      cpu_we   = stall && (k % 3 == 2);
      cpu_addr = 10'h3E0;
      cpu_data = 8'h55;
      tick();
      k++;
    end
    cpu_we = 1'b0;
    if (k >= 6000) chk("bulk_timeout", 32'(busy), 32'd0);
    dur = k;
  endtask

  task automatic check_log(input string tag);
    int n_bad = 0;
    chk({tag, "_wr_count"}, 32'(eng_log.size() - log_base), 32'(exp_q.size()));
    if (eng_log.size() - log_base == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) if (eng_log[log_base + i] !== exp_q[i]) n_bad++;
      chk({tag, "_wr_content"}, 32'(n_bad), 32'd0);
    end
    exp_q.delete();
    log_base = eng_log.size();
  endtask

  task automatic chk_cursor(input string tag);
    chk({tag, "_row"}, 32'(cursor_row), 32'(m_row));
    chk({tag, "_col"}, 32'(cursor_col), 32'(m_col));
  endtask

  function automatic logic [7:0] rnd_print();
    logic [7:0] v;
    v = 8'($urandom_range(32, 127));
    if ($urandom_range(0, 3) == 0) v[7] = 1'b1;
    return v;
  endfunction

  initial begin
    int dur, k_exp, base55;
    logic [7:0] d;
    rst = 1'b1; char_valid = 1'b0; char_data = 8'h00; char_color = 1'b0;
    cpu_we = 1'b1; cpu_addr = 10'h155; cpu_data = 8'hAA;
    m_row = 0; m_col = 0; log_base = 0;
    repeat (3) tick();
    chk("rst_ready", 32'(char_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_row", 32'(cursor_row), 32'd0);
    chk("rst_col", 32'(cursor_col), 32'd0);
    chk("rst_raddr", 32'(txbl_raddr), 32'd0);
    chk("rst_cpu_pass", {13'd0, txbl_we, txbl_waddr, txbl_wdata}, {13'd0, 1'b1, 10'h155, 8'hAA});
    cpu_we = 1'b0;
    #1;
    chk("rst_we_idle", 32'(txbl_we), 32'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 32'(char_ready), 32'd1);

    // Known random contents in every cell, written through the CPU port
    for (int i = 0; i < 1024; i++) begin
      cpu_we = 1'b1; cpu_addr = 10'(i); cpu_data = 8'($urandom);
      exp_mem[i] = cpu_data;
      tick();
    end
    cpu_we = 1'b0;
    tick();
    chk("fill_mem", 32'(mem_diff()), 32'd0);
    log_base = eng_log.size();

    // 'A' with colour: write one cycle after accept, ready back the cycle after
    char_valid = 1'b1; char_data = 8'h41; char_color = 1'b1;
    tick();
    char_valid = 1'b0;
    m_char(8'h41, 1'b1);
    chk("a_write", {13'd0, txbl_we, txbl_waddr, txbl_wdata}, {13'd0, 1'b1, 10'h000, 8'hC1});
    chk("a_ready_low", 32'(char_ready), 32'd0);
    tick();
    chk("a_ready_back", 32'(char_ready), 32'd1);
    chk_cursor("a_cursor");
    check_log("a");

    // Cursor to (5,31), then 'Z' wraps to (6,0) without scrolling
    repeat (5) send(8'h0A, 1'b0);
    for (int i = 0; i < COLS - 1; i++) send(rnd_print(), 1'($urandom));
    chk_cursor("pre_z");
    send(8'h5A, 1'b0);
    chk("z_cursor_row", 32'(cursor_row), 32'd6);
    chk("z_cursor_col", 32'(cursor_col), 32'd0);
    chk("z_cell", 32'(mem[10'h0BF]), 32'h5A);
    check_log("print_row");

    // Plain scroll from (29,0)
    while (m_row < ROWS - 1) send(8'h0A, 1'b0);
    chk_cursor("pre_scroll");
    push_byte(8'h0A, 1'b0);
    run_bulk(1'b0, dur);
    chk("scroll_cycles", 32'(dur), 32'(sched(1'b0)));
    chk("scroll_cycles_abs", 32'(dur), 32'd1888);
    chk("scroll_eng_writes", 32'(eng_log.size() - log_base), 32'((ROWS - 1) * COLS + COLS));
    chk("scroll_mem", 32'(mem_diff()), 32'd0);
    chk_cursor("scroll_cursor");
    log_base = eng_log.size();

    // Scroll with CPU writes every third cycle
    base55 = cpu55_cnt;
    push_byte(8'h0A, 1'b0);
    run_bulk(1'b1, dur);
    exp_mem[10'h3E0] = 8'h55;
    chk("stall_cycles", 32'(dur), 32'(sched(1'b1)));
    k_exp = 0;
    for (int j = 0; j < dur; j++) if (j % 3 == 2) k_exp++;
    chk("stall_cpu_writes", 32'(cpu55_cnt - base55), 32'(k_exp));
    chk("stall_eng_writes", 32'(eng_log.size() - log_base), 32'((ROWS - 1) * COLS + COLS));
    chk("stall_mem", 32'(mem_diff()), 32'd0);
    chk("stall_3e0", 32'(mem[10'h3E0]), 32'h55);
    chk_cursor("stall_cursor");
    log_base = eng_log.size();

    // Clear from (10,7), then BS at column 0
    send(8'h0C, 1'b0);
    repeat (10) send(8'h0A, 1'b0);
    repeat (7) send(rnd_print(), 1'($urandom));
    chk("pre_ff_col", 32'(cursor_col), 32'd7);
    exp_q.delete();
    log_base = eng_log.size();
    push_byte(8'h0C, 1'b0);
    run_bulk(1'b0, dur);
    chk("clear_cycles", 32'(dur), 32'd960);
    chk("clear_eng_writes", 32'(eng_log.size() - log_base), 32'd960);
    chk("clear_mem", 32'(mem_diff()), 32'd0);
    chk("clear_cursor_row", 32'(cursor_row), 32'd0);
    chk("clear_cursor_col", 32'(cursor_col), 32'd0);
    log_base = eng_log.size();
    send(8'h08, 1'b0);
    chk_cursor("bs_col0");
    send(8'h2B, 1'b1);
    send(8'h08, 1'b0);
    chk_cursor("bs_col1");
    check_log("bs");

    // TAB from (3,5) and (3,30)
    repeat (3) send(8'h0A, 1'b0);
    repeat (5) send(rnd_print(), 1'b0);
    send(8'h09, 1'b0);
    chk_cursor("tab_mid");
`ifdef TXCON_TAB_EN
    chk("tab_mid_col_abs", 32'(cursor_col), 32'd8);
`else
    chk("tab_mid_col_abs", 32'(cursor_col), 32'd5);
`endif
    send(8'h0D, 1'b0);
    repeat (30) send(rnd_print(), 1'b1);
    send(8'h09, 1'b0);
    chk_cursor("tab_wrap");
    check_log("tab");
    chk("tab_mem", 32'(mem_diff()), 32'd0);

    // Randomized byte stream against the screen model
    for (int i = 0; i < 120; i++) begin
      int sel = $urandom_range(0, 99);
      if (sel < 68) d = rnd_print();
      else if (sel < 76) d = 8'h0A;
      else if (sel < 82) d = 8'h0D;
      else if (sel < 88) d = 8'h08;
      else if (sel < 93) d = 8'h09;
      else if (sel < 94) d = 8'h0C;
      else d = 8'($urandom_range(0, 31));
      send(d, 1'($urandom));
      chk_cursor("rnd_cursor");
    end
    chk("rnd_mem", 32'(mem_diff()), 32'd0);

    // Reset in the middle of a clear
    push_byte(8'h0C, 1'b0);
    repeat (50) tick();
    rst = 1'b1;
    tick();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(char_ready), 32'd0);
    chk("midrst_row", 32'(cursor_row), 32'd0);
    chk("midrst_col", 32'(cursor_col), 32'd0);
    chk("midrst_we", 32'(txbl_we), 32'd0);
    chk("midrst_raddr", 32'(txbl_raddr), 32'd0);
    rst = 1'b0;
    tick();
    chk("midrst_ready_back", 32'(char_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
